// File: rtl/miriscv_dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_dmem_pkg
//  Description : Shared types and defaults for the LSU-to-bus data-memory
//                bridge (FSM state encoding, width and watchdog defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package miriscv_dmem_pkg;

    localparam int c_DMEM_XLEN            = 32;
    localparam int c_DMEM_TIMEOUT_CYCLES  = 256;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_REQ  = 2'd1,
        DMEM_WAIT = 2'd2,
        DMEM_DONE = 2'd3
    } dmem_state_e;

endpackage : miriscv_dmem_pkg
`default_nettype wire

// File: rtl/miriscv_dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_dmem_bridge
//  Description : Converts the LSU's level-held data request into a single
//                valid/ready bus request plus a response phase, tracks the
//                one outstanding access and returns a one-cycle rvalid pulse.
//                Killed accesses finish on the bus but are not reported.
//  Options     : MIRISCV_DMEM_TIMEOUT_EN - adds a WAIT-state watchdog that
//                aborts with an error after TIMEOUT_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module miriscv_dmem_bridge
    import miriscv_dmem_pkg::*;
#(
    parameter int XLEN = c_DMEM_XLEN
`ifdef MIRISCV_DMEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = c_DMEM_TIMEOUT_CYCLES
`endif
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    // LSU side
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [XLEN/8-1:0] lsu_be_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    // Bus side
    output logic              bus_req_valid_o,
    input  logic              bus_req_ready_i,
    output logic              bus_req_we_o,
    output logic [XLEN/8-1:0] bus_req_be_o,
    output logic [XLEN-1:0]   bus_req_addr_o,
    output logic [XLEN-1:0]   bus_req_wdata_o,
    input  logic              bus_rsp_valid_i,
    input  logic [XLEN-1:0]   bus_rsp_rdata_i,
    input  logic              bus_rsp_err_i,
    output logic              bus_err_o
);

    dmem_state_e        r_state;
    dmem_state_e        w_state_next;

    logic               r_we;
    logic [XLEN/8-1:0]  r_be;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [XLEN-1:0]    r_rdata;
    logic               r_err;
    logic               r_drop;

    logic               w_capture;
    logic               w_rsp_take;
    logic               w_timeout;
    logic               w_kill;

`ifdef MIRISCV_DMEM_TIMEOUT_EN
    localparam int c_TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_TCNT_W-1:0] r_tcnt;
    logic                w_tcnt_expired;

    assign w_tcnt_expired = (r_tcnt == c_TCNT_LAST);

    // Watchdog counter: cleared on entry to WAIT, counts every WAIT cycle
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_tcnt <= '0;
        end else if ((r_state == DMEM_REQ) && bus_req_ready_i) begin
            r_tcnt <= '0;
        end else if (r_state == DMEM_WAIT) begin
            r_tcnt <= r_tcnt + c_TCNT_W'(1);
        end
    end
`else
    logic w_tcnt_expired;

    assign w_tcnt_expired = 1'b0;
`endif

    // LSU dropping its request while the access is in flight marks it killed
    assign w_kill = ((r_state == DMEM_REQ) || (r_state == DMEM_WAIT)) && !lsu_req_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_state <= DMEM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        w_state_next    = r_state;
        w_capture       = 1'b0;
        w_rsp_take      = 1'b0;
        w_timeout       = 1'b0;
        bus_req_valid_o = 1'b0;
        lsu_rvalid_o    = 1'b0;
        bus_err_o       = 1'b0;
        case (r_state)
            DMEM_IDLE: begin
                if (lsu_req_i) begin
                    w_capture    = 1'b1;
                    w_state_next = DMEM_REQ;
                end
            end
            DMEM_REQ: begin
                bus_req_valid_o = 1'b1;
                if (bus_req_ready_i) begin
                    w_state_next = DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                // A response in the expiry cycle wins over the watchdog
                if (bus_rsp_valid_i) begin
                    w_rsp_take   = 1'b1;
                    w_state_next = DMEM_DONE;
                end else if (w_tcnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = DMEM_DONE;
                end
            end
            DMEM_DONE: begin
                lsu_rvalid_o = !r_drop;
                bus_err_o    = r_err;
                w_state_next = DMEM_IDLE;
            end
            default: begin
                w_state_next = DMEM_IDLE;
            end
        endcase
    end

    // Access capture, kill tracking and response capture
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_we    <= lsu_we_i;
                r_be    <= lsu_be_i;
                r_addr  <= lsu_addr_i;
                r_wdata <= lsu_wdata_i;
                r_drop  <= 1'b0;
            end
            if (w_kill) begin
                r_drop <= 1'b1;
            end
            if (w_rsp_take) begin
                // Stores leave the last load data visible to the LSU
                if (!r_we) begin
                    r_rdata <= bus_rsp_rdata_i;
                end
                r_err <= bus_rsp_err_i;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus_req_we_o    = r_we;
    assign bus_req_be_o    = r_be;
    assign bus_req_addr_o  = r_addr;
    assign bus_req_wdata_o = r_wdata;
    assign lsu_rdata_o     = r_rdata;

endmodule : miriscv_dmem_bridge
`default_nettype wire
